// File: rtl/pipe_scoreboard_if.sv
// Issue-stage handshake between decode and the hazard/forwarding scoreboard.
// The decode side (master) presents the instruction; the scoreboard (slave) answers.
interface pipe_scoreboard_if #(
    parameter int DEPTH = 2,
    parameter int SELW  = $clog2(DEPTH + 1)
);
    logic             stall;
    logic             flush;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_rd_we;
    logic             id_is_load;

    logic             issue_stall;
    logic [SELW-1:0]  fwd1_sel;
    logic [SELW-1:0]  fwd2_sel;
    logic [DEPTH-1:0] slot_valid;
    logic             wb_we;
    logic [4:0]       wb_rd;

    modport master (
        output stall, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load,
        input  issue_stall, fwd1_sel, fwd2_sel, slot_valid, wb_we, wb_rd
    );

    modport slave (
        input  stall, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load,
        output issue_stall, fwd1_sel, fwd2_sel, slot_valid, wb_we, wb_rd
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Hazard and forwarding controller: tracks destinations of DEPTH in-flight
// instructions (execute..writeback), interlocks load-use, picks forward sources.
module pipe_scoreboard #(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    pipe_scoreboard_if.slave  sb
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    typedef struct packed {
        logic            hazard;
        logic [SELW-1:0] sel;
    } fwd_t;

    slot_t slots [DEPTH];
    fwd_t  fwd1;
    fwd_t  fwd2;
    logic  issue_ok;

    // Scan oldest to youngest so the youngest matching slot overrides; a match
    // on a load still inside its latency window blocks any older producer.
    function automatic fwd_t lookup(input logic [4:0] src, input logic used);
        fwd_t r;
        // NOTE: every combinational result gets a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && src != 5'd0 && slots[k].valid && slots[k].rd == src) begin
                r.hazard = slots[k].is_load && (k < LOAD_LAT);
                r.sel    = r.hazard ? '0 : SELW'(k + 1);
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd1 = lookup(sb.id_rs1, sb.id_rs1_used);
        fwd2 = lookup(sb.id_rs2, sb.id_rs2_used);
    end

    // Flush dominates a hazard: the squashed instruction never needs to wait.
    assign sb.issue_stall = sb.id_valid & ~sb.flush & (fwd1.hazard | fwd2.hazard);
    assign sb.fwd1_sel    = fwd1.sel;
    assign sb.fwd2_sel    = fwd2.sel;
    assign issue_ok       = sb.id_valid & ~sb.flush & ~sb.issue_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slot array is a handful of flops, and wb_rd must read 0
            // after reset, so every field is cleared rather than only valid.
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
        end else if (!sb.stall) begin
            // NOTE: non-blocking assignments make the shift read the old slot
            // contents regardless of loop order.
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
            if (issue_ok && sb.id_rd_we && sb.id_rd != 5'd0) begin
                slots[0] <= '{valid: 1'b1, rd: sb.id_rd, is_load: sb.id_is_load};
            end else begin
                slots[0] <= '0;
            end
        end
    end

    always_comb begin
        sb.slot_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sb.slot_valid[k] = slots[k].valid;
        end
    end

    assign sb.wb_we = slots[DEPTH-1].valid;
    assign sb.wb_rd = slots[DEPTH-1].rd;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench: a DEPTH=2/LOAD_LAT=1 instance (a) and a DEPTH=3/LOAD_LAT=2
// instance (b) share stimulus; each step is checked against hand-derived values.
module tb_pipe_scoreboard;

    logic clk;
    logic reset;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    pipe_scoreboard_if #(.DEPTH(2)) ifa ();
    pipe_scoreboard_if #(.DEPTH(3)) ifb ();

    pipe_scoreboard #(.DEPTH(2), .LOAD_LAT(1)) dut_a (.clk(clk), .reset(reset), .sb(ifa.slave));
    pipe_scoreboard #(.DEPTH(3), .LOAD_LAT(2)) dut_b (.clk(clk), .reset(reset), .sb(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
        ifa.id_valid = v;   ifb.id_valid = v;
        ifa.id_rs1 = rs1;   ifb.id_rs1 = rs1;
        ifa.id_rs2 = rs2;   ifb.id_rs2 = rs2;
        ifa.id_rs1_used = u1; ifb.id_rs1_used = u1;
        ifa.id_rs2_used = u2; ifb.id_rs2_used = u2;
        ifa.id_rd = rd;     ifb.id_rd = rd;
        ifa.id_rd_we = we;  ifb.id_rd_we = we;
        ifa.id_is_load = ld; ifb.id_is_load = ld;
    endtask

    task automatic set_ctl(input logic st, input logic fl);
        ifa.stall = st; ifb.stall = st;
        ifa.flush = fl; ifb.flush = fl;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic randomize_id();
        set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(negedge clk);
            set_ctl(1'b0, 1'b0);
            idle();
        end
    endtask

    initial begin
        // Reset with random id_* for two edges
        reset = 1'b1;
        set_ctl(1'b0, 1'b0);
        randomize_id();
        @(negedge clk);
        randomize_id();
        @(negedge clk);
        #1;
        check("rst_a_slotv", 32'(ifa.slot_valid), 0);
        check("rst_a_wbwe", 32'(ifa.wb_we), 0);
        check("rst_a_wbrd", 32'(ifa.wb_rd), 0);
        check("rst_a_stall", 32'(ifa.issue_stall), 0);
        check("rst_a_fwd1", 32'(ifa.fwd1_sel), 0);
        check("rst_a_fwd2", 32'(ifa.fwd2_sel), 0);
        check("rst_b_slotv", 32'(ifb.slot_valid), 0);
        check("rst_b_stall", 32'(ifb.issue_stall), 0);
        reset = 1'b0;
        idle();

        // ALU chain: add x5; add x6<-x5; add x7<-x5; add x9<-x5
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); #1;
        check("alu1_a_fwd1", 32'(ifa.fwd1_sel), 0);
        check("alu1_a_stall", 32'(ifa.issue_stall), 0);
        @(negedge clk); set_id(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0); #1;
        check("alu2_a_fwd1", 32'(ifa.fwd1_sel), 1);
        check("alu2_a_fwd2", 32'(ifa.fwd2_sel), 0);
        check("alu2_a_slotv", 32'(ifa.slot_valid), 1);
        check("alu2_b_fwd1", 32'(ifb.fwd1_sel), 1);
        @(negedge clk); set_id(1, 5'd5, 5'd2, 1, 1, 5'd7, 1, 0); #1;
        check("alu3_a_fwd1", 32'(ifa.fwd1_sel), 2);
        check("alu3_a_wbwe", 32'(ifa.wb_we), 1);
        check("alu3_a_wbrd", 32'(ifa.wb_rd), 5);
        check("alu3_a_slotv", 32'(ifa.slot_valid), 3);
        check("alu3_b_fwd1", 32'(ifb.fwd1_sel), 2);
        @(negedge clk); set_id(1, 5'd5, 5'd2, 1, 1, 5'd9, 1, 0); #1;
        check("alu4_a_fwd1", 32'(ifa.fwd1_sel), 0);
        check("alu4_a_wbrd", 32'(ifa.wb_rd), 6);
        check("alu4_b_fwd1", 32'(ifb.fwd1_sel), 3);
        check("alu4_b_wbrd", 32'(ifb.wb_rd), 5);
        drain(3);

        // Load-use on a (LOAD_LAT=1): one stall cycle, then sel=2
        @(negedge clk); set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1); #1;
        check("lu1_a_stall", 32'(ifa.issue_stall), 0);
        @(negedge clk); set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0); #1;
        check("lu2_a_stall", 32'(ifa.issue_stall), 1);
        @(negedge clk); #1;
        check("lu3_a_stall", 32'(ifa.issue_stall), 0);
        check("lu3_a_fwd1", 32'(ifa.fwd1_sel), 2);
        check("lu3_a_slotv", 32'(ifa.slot_valid), 2);
        @(negedge clk); idle(); #1;
        check("lu4_a_slotv", 32'(ifa.slot_valid), 1);
        drain(3);

        // Load-use on b (DEPTH=3, LOAD_LAT=2): two stall cycles, then sel=3
        @(negedge clk); set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1); #1;
        check("lub1_b_stall", 32'(ifb.issue_stall), 0);
        @(negedge clk); set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0); #1;
        check("lub2_b_stall", 32'(ifb.issue_stall), 1);
        @(negedge clk); #1;
        check("lub3_b_stall", 32'(ifb.issue_stall), 1);
        check("lub3_b_slotv", 32'(ifb.slot_valid), 2);
        @(negedge clk); #1;
        check("lub4_b_stall", 32'(ifb.issue_stall), 0);
        check("lub4_b_fwd1", 32'(ifb.fwd1_sel), 3);
        check("lub4_b_slotv", 32'(ifb.slot_valid), 4);
        drain(3);

        // Youngest wins, then an unused matching rs2
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        @(negedge clk); set_id(1, 5'd3, 5'd3, 1, 1, 5'd10, 0, 0); #1;
        check("yw_a_fwd1", 32'(ifa.fwd1_sel), 1);
        check("yw_a_fwd2", 32'(ifa.fwd2_sel), 1);
        check("yw_b_fwd1", 32'(ifb.fwd1_sel), 1);
        check("yw_b_fwd2", 32'(ifb.fwd2_sel), 1);
        @(negedge clk); set_id(1, 5'd3, 5'd3, 1, 0, 5'd10, 0, 0); #1;
        check("unused_a_fwd1", 32'(ifa.fwd1_sel), 2);
        check("unused_a_fwd2", 32'(ifa.fwd2_sel), 0);
        drain(3);

        // x0 is never tracked
        @(negedge clk); set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0);
        @(negedge clk); set_id(1, 5'd0, 5'd0, 1, 1, 5'd11, 0, 0); #1;
        check("x0_a_fwd1", 32'(ifa.fwd1_sel), 0);
        check("x0_a_fwd2", 32'(ifa.fwd2_sel), 0);
        check("x0_a_slotv", 32'(ifa.slot_valid), 0);
        @(negedge clk); idle(); #1;
        check("x0_a_wbwe", 32'(ifa.wb_we), 0);
        drain(3);

        // Global stall holds slots; combinational forwarding still works
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0);
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_ctl(1'b1, 1'b0); set_id(1, 5'd9, 5'd4, 1, 1, 5'd12, 0, 0); #1;
            check($sformatf("st%0d_a_slotv", i), 32'(ifa.slot_valid), 3);
            check($sformatf("st%0d_a_wbrd", i), 32'(ifa.wb_rd), 4);
            check($sformatf("st%0d_a_fwd1", i), 32'(ifa.fwd1_sel), 1);
            check($sformatf("st%0d_a_fwd2", i), 32'(ifa.fwd2_sel), 2);
        end
        @(negedge clk); set_ctl(1'b0, 1'b0); idle(); #1;
        check("st_end_a_slotv", 32'(ifa.slot_valid), 3);
        check("st_end_a_wbrd", 32'(ifa.wb_rd), 4);
        drain(3);

        // Flush beats a load-use hazard and inserts a bubble
        @(negedge clk); set_id(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);
        @(negedge clk); set_ctl(1'b0, 1'b1); set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0); #1;
        check("fl_a_stall", 32'(ifa.issue_stall), 0);
        check("fl_b_stall", 32'(ifb.issue_stall), 0);
        @(negedge clk); set_ctl(1'b0, 1'b0); idle(); #1;
        check("fl_a_slotv", 32'(ifa.slot_valid), 2);
        check("fl_b_slotv", 32'(ifb.slot_valid), 2);
        drain(3);

        // Reset while stalled discards all in-flight entries
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0);
        @(negedge clk); set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        @(negedge clk); set_ctl(1'b1, 1'b0); reset = 1'b1; idle(); #1;
        check("rs_pre_a_slotv", 32'(ifa.slot_valid), 3);
        @(negedge clk); set_ctl(1'b0, 1'b0); reset = 1'b0; #1;
        check("rs_a_slotv", 32'(ifa.slot_valid), 0);
        check("rs_a_wbwe", 32'(ifa.wb_we), 0);
        check("rs_a_wbrd", 32'(ifa.wb_rd), 0);
        check("rs_b_slotv", 32'(ifb.slot_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
